dac_i2s_tx: RTL and testbench
=============================

Name: dac_i2s_tx

Overview:
- Serial sample transmitter for the synth's audio DAC.
- It sits downstream of the DAC reset sequencer and stays silent until that sequencer's ready flag is high.
- Once ready, it generates BCLK/LRCLK and shifts 16-bit stereo samples out in standard I2S format: MSB one BCLK after the LRCLK edge, left channel while LRCLK is low.
- Samples arrive from the voice mixer over a valid/ready handshake through a one-deep holding register.

Parameters:
- DATA_W, 16, sample width per channel (max 31).
- BCLK_HALF, 2, clk12Mhz cycles per BCLK half-period (BCLK = 3 MHz at default); must be >= 1.
- SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS BCLKs.

Ports:
- clk12Mhz  input  1  system clock, 12 MHz.
- RESET_n  input  1  asynchronous active-low reset.
- dac_ready  input  1  DAC reset sequence complete (from reset sequencer).
- sample_l  input  DATA_W  left sample, two's complement.
- sample_r  input  DATA_W  right sample, two's complement.
- sample_valid  input  1  sample pair presented.
- sample_ready  output  1  holding register empty; transfer occurs on valid&ready.
- bclk  output  1  DAC bit clock.
- lrclk  output  1  word select, 0 = left.
- sdata  output  1  serial data, changes only on bclk falling edge.
- underrun  output  1  one-cycle pulse: frame started with empty holding register.

Behaviour:
- Reset (async assert, sync release) clears bclk, lrclk, sdata, sample_ready, underrun, holding register, shift registers, div counter, bit counter (bc); state = IDLE.
- IDLE:
  - All serial outputs are 0 and sample_ready=0.
  - On a clock edge with dac_ready=1, go to RUN.
  - On entry to RUN: bc=0, div=0, bclk=0, lrclk=0, and a frame load is performed (see Frame load).
- RUN bit clock generation:
  - div counts 0..BCLK_HALF-1 and wraps; at div==BCLK_HALF-1, bclk toggles.
  - On each falling toggle (1->0), bc increments modulo 2*SLOT_BITS.
  - lrclk and sdata update in the same cycle as that falling toggle.
- lrclk = 1 for bc in SLOT_BITS..2*SLOT_BITS-1, 0 otherwise.
- sdata:
  - bc=1..DATA_W carries L[DATA_W-bc] (MSB first).
  - bc=SLOT_BITS+1..SLOT_BITS+DATA_W carries R[...] MSB first.
  - All other bc values carry 0.
- Frame load occurs on bc wrap 2*SLOT_BITS-1 -> 0 and on RUN entry:
  - If the holding register is full, copy it to the shift registers and mark it empty.
  - If it is empty, load zeros and pulse underrun for 1 cycle.
  - No bypass: a sample accepted in the same cycle as a load goes to the holding register, and the load sees empty.
- sample_ready = (state==RUN) & holding empty; combinational from registered state.
  - Accept on valid&ready at a clock edge; the holding register becomes full the next cycle.
- dac_ready deasserting in RUN, on any cycle including mid-frame:
  - Next cycle returns to IDLE with outputs 0, holding emptied, and no underrun pulse.
  - The pending sample is discarded.
- RESET_n asserted mid-frame: immediate async clear; bclk is allowed to truncate.
- Frame length = 2*SLOT_BITS*2*BCLK_HALF clocks (256 at defaults). Sample rate = 46.875 kHz at defaults.
- Latency from accept to first MSB on sdata: wait for the next frame load, then 2*BCLK_HALF clocks after that load.

Test Plan:
1. Reset with dac_ready=0 for 100 clocks -> bclk=lrclk=sdata=0 and sample_ready=0 throughout.
2. Raise dac_ready, then send L=16'hA5C3, R=16'h8001 (before the second frame) -> second frame sdata shows 1010010111000011 on bc 1..16 and 1000000000000001 on bc 33..48; bclk period is 4 clocks and lrclk period is 256 clocks.
3. Hold sample_valid=0 after RUN entry -> underrun pulses once every 256 clocks and sdata stays 0.
4. Present a sample on the exact cycle of a frame load with the holding register empty -> underrun pulses; that sample appears in the following frame.
5. Drop dac_ready at bc=10 -> next cycle all outputs are 0 and state is IDLE; re-raise it -> new frame starts at bc=0 with an underrun pulse.
6. Assert RESET_n low mid-frame with the holding register full -> outputs clear asynchronously; after release and dac_ready=1 the first frame is zeros with underrun.

Source files
------------

// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: I2S stereo transmitter for the audio DAC. It waits for the DAC sequencer's
// ready flag and takes sample pairs through a one-deep holding register.
module dac_i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int BCLK_HALF = 2,
    parameter int SLOT_BITS = 32
) (
    input  logic              clk12Mhz,
    input  logic              RESET_n,
    input  logic              dac_ready,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BC_W  = $clog2(FRAME);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME - 1);
    localparam logic [BC_W-1:0]  L_HI     = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]  R_LO     = BC_W'(SLOT_BITS + 1);
    localparam logic [BC_W-1:0]  R_HI     = BC_W'(SLOT_BITS + DATA_W);
    localparam logic [BC_W-1:0]  SLOT     = BC_W'(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_state_nx;
    logic [DIV_W-1:0]  r_div;
    logic [BC_W-1:0]   r_bc;
    logic              r_bclk, r_lrclk, r_sdata, r_underrun, r_full;
    logic [DATA_W-1:0] r_hold_l, r_hold_r, r_sh_l, r_sh_r;

    logic              w_start, w_run, w_tick, w_fall, w_load, w_acc, w_in_l, w_in_r;
    logic [BC_W-1:0]   w_bc_nx;

    always_ff @(posedge clk12Mhz or negedge RESET_n) begin
        if (!RESET_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = dac_ready ? RUN : IDLE;
    end

    always_comb begin
        sample_ready = (r_state == RUN) && !r_full;
        bclk         = r_bclk;
        lrclk        = r_lrclk;
        sdata        = r_sdata;
        underrun     = r_underrun;
    end

    assign w_start = (r_state == IDLE) && dac_ready;
    assign w_run   = (r_state == RUN) && dac_ready;
    assign w_tick  = (r_div == DIV_LAST);
    assign w_fall  = w_run && w_tick && r_bclk;
    assign w_bc_nx = (r_bc == BC_LAST) ? '0 : r_bc + 1'b1;
    assign w_load  = w_start || (w_fall && (w_bc_nx == '0));
    assign w_acc   = sample_valid && sample_ready;
    assign w_in_l  = (w_bc_nx != '0) && (w_bc_nx <= L_HI);
    assign w_in_r  = (w_bc_nx >= R_LO) && (w_bc_nx <= R_HI);

    always_ff @(posedge clk12Mhz or negedge RESET_n) begin
        if (!RESET_n) begin
            r_div      <= '0;
            r_bc       <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_sh_l     <= '0;
            r_sh_r     <= '0;
        end else if (!w_run && !w_start) begin
            // idle, or dac_ready dropped: silence and discard any pending sample
            r_div      <= '0;
            r_bc       <= '0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_acc) begin
                r_full   <= 1'b1;
                r_hold_l <= sample_l;
                r_hold_r <= sample_r;
            end
            if (w_start) begin
                r_div   <= '0;
                r_bc    <= '0;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                r_sdata <= 1'b0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) r_bclk <= ~r_bclk;
                if (w_fall) begin
                    r_bc    <= w_bc_nx;
                    r_lrclk <= (w_bc_nx >= SLOT);
                    r_sdata <= w_in_l ? r_sh_l[DATA_W-1] : w_in_r ? r_sh_r[DATA_W-1] : 1'b0;
                    if (w_in_l) r_sh_l <= r_sh_l << 1;
                    if (w_in_r) r_sh_r <= r_sh_r << 1;
                end
            end
            // the load sees the pre-accept holding state, so a same-cycle sample waits a frame
            if (w_load) begin
                r_sh_l     <= r_full ? r_hold_l : '0;
                r_sh_r     <= r_full ? r_hold_r : '0;
                r_underrun <= !r_full;
                if (r_full) r_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb_dac_i2s_tx: randomized bench for dac_i2s_tx against a clock-count model of the
// I2S frame (bit position and frame number derived from cycles since RUN entry).
module tb_dac_i2s_tx;
    logic        clk12Mhz = 1'b0;
    logic        RESET_n;
    logic        dac_ready;
    logic [15:0] sample_l, sample_r;
    logic        sample_valid;
    logic        sample_ready, bclk, lrclk, sdata, underrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state: m_k = clock edges since RUN entry
    bit          m_run  = 0;
    bit          m_full = 0;
    bit          m_und  = 0;
    bit          m_acc  = 0;
    int          m_k    = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;

    int          cap_frame = -1;
    logic [15:0] cap_l = '0, cap_r = '0;

    dac_i2s_tx dut (
        .clk12Mhz    (clk12Mhz),
        .RESET_n     (RESET_n),
        .dac_ready   (dac_ready),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .underrun    (underrun)
    );

    always #5 clk12Mhz = ~clk12Mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic load_frame();
        m_fl  = m_full ? m_hl : 16'h0;
        m_fr  = m_full ? m_hr : 16'h0;
        m_und = !m_full;
        m_full = 0;
    endtask

    task automatic compare_all();
        int bc;
        bit e_b, e_lr, e_sd;
        bc   = (m_k / 4) % 64;
        e_b  = m_run && ((m_k / 2) % 2 == 1);
        e_lr = m_run && (bc >= 32);
        e_sd = !m_run ? 1'b0 :
               (bc >= 1 && bc <= 16)  ? m_fl[16-bc] :
               (bc >= 33 && bc <= 48) ? m_fr[48-bc] : 1'b0;
        chk("bclk", 32'(bclk), 32'(e_b));
        chk("lrclk", 32'(lrclk), 32'(e_lr));
        chk("sdata", 32'(sdata), 32'(e_sd));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("sample_ready", 32'(sample_ready), 32'(m_run && !m_full));
        if (m_run && (m_k / 256) == cap_frame && (m_k % 4) == 0) begin
            if (bc >= 1 && bc <= 16)  cap_l[16-bc] = sdata;
            if (bc >= 33 && bc <= 48) cap_r[48-bc] = sdata;
        end
    endtask

    task automatic step();
        bit pre_rdy;
        @(posedge clk12Mhz);
        cyc++;
        pre_rdy = m_run && !m_full;
        m_acc = 0;
        m_und = 0;
        if (!RESET_n || !dac_ready) begin
            m_run  = 0;
            m_full = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_k   = 0;
            load_frame();
        end else begin
            m_k++;
            if (m_k % 256 == 0) load_frame();
            if (sample_valid && pre_rdy) begin
                m_full = 1;
                m_hl   = sample_l;
                m_hr   = sample_r;
                m_acc  = 1;
            end
        end
        @(negedge clk12Mhz);
        compare_all();
    endtask

    task automatic feed(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (m_acc) break;
        end
        chk("feed_accepted", 32'(m_acc), 1);
        sample_valid = 0;
    endtask

    initial begin
        int lb, llr, bper, lper, und_cnt, ones;
        logic [15:0] dl, dr;
        bit pb, plr;
        RESET_n = 0; dac_ready = 0; sample_valid = 0; sample_l = '0; sample_r = '0;
        repeat (3) step();
        RESET_n = 1;
        // idle with dac_ready low: everything silent
        repeat (100) step();

        dac_ready = 1;
        step();
        chk("t2_entry_und", 32'(underrun), 1);
        feed(16'hA5C3, 16'h8001);
        cap_frame = 1;
        lb = -1; llr = -1; bper = 0; lper = 0;
        for (int i = 0; i < 600 && m_k < 511; i++) begin
            pb = bclk; plr = lrclk;
            step();
            if (!pb && bclk) begin if (lb >= 0) bper = cyc - lb; lb = cyc; end
            if (!plr && lrclk) begin if (llr >= 0) lper = cyc - llr; llr = cyc; end
        end
        chk("t2_left_bits", 32'(cap_l), 32'h0000A5C3);
        chk("t2_right_bits", 32'(cap_r), 32'h00008001);
        chk("t2_bclk_period", 32'(bper), 4);
        chk("t2_lrclk_period", 32'(lper), 256);

        und_cnt = 0; ones = 0;
        repeat (768) begin
            step();
            und_cnt += int'(underrun);
            ones    += int'(sdata);
        end
        chk("t3_underruns", 32'(und_cnt), 3);
        chk("t3_sdata_ones", 32'(ones), 0);

        for (int i = 0; i < 300 && (m_k % 256) != 255; i++) step();
        dl = 16'($urandom); dr = 16'($urandom);
        sample_l = dl; sample_r = dr; sample_valid = 1;
        step();
        sample_valid = 0;
        chk("t4_und_on_load", 32'(underrun), 1);
        chk("t4_held", 32'(sample_ready), 0);
        cap_frame = m_k / 256 + 1;
        cap_l = '0; cap_r = '0;
        for (int i = 0; i < 600 && m_k < cap_frame * 256 + 255; i++) step();
        chk("t4_left_next_frame", 32'(cap_l), 32'(dl));
        chk("t4_right_next_frame", 32'(cap_r), 32'(dr));

        for (int i = 0; i < 400 && !((m_k % 4) == 0 && (m_k / 4) % 64 == 10); i++) step();
        chk("t5_reached_bc10", 32'((m_k / 4) % 64), 10);
        dac_ready = 0;
        step();
        chk("t5_idle_outputs", {27'd0, bclk, lrclk, sdata, underrun, sample_ready}, 0);
        repeat (5) step();
        dac_ready = 1;
        step();
        chk("t5_reentry_und", 32'(underrun), 1);
        chk("t5_reentry_lrclk", 32'(lrclk), 0);
        repeat (20) step();

        dac_ready = 0; step(); dac_ready = 1; step();
        feed(16'h7FFF, 16'h1234);
        for (int i = 0; i < 400 && !((m_k % 4) == 2 && (m_k / 4) % 64 == 40); i++) step();
        chk("t6_pre_bclk", 32'(bclk), 1);
        chk("t6_pre_full", 32'(sample_ready), 0);
        RESET_n = 0;
        #1;
        chk("t6_async_clear", {28'd0, bclk, lrclk, sdata, sample_ready}, 0);
        m_run = 0; m_full = 0; m_und = 0;
        repeat (3) step();
        RESET_n = 1;
        step();
        chk("t6_first_und", 32'(underrun), 1);
        ones = 0;
        for (int i = 0; i < 300 && m_k < 255; i++) begin step(); ones += int'(sdata); end
        chk("t6_zero_frame", 32'(ones), 0);

        for (int i = 0; i < 6000; i++) begin
            if (!sample_valid && $urandom_range(3) == 0) begin
                sample_valid = 1;
                sample_l = 16'($urandom);
                sample_r = 16'($urandom);
            end
            if (dac_ready && $urandom_range(999) == 0) dac_ready = 0;
            else if (!dac_ready && $urandom_range(7) == 0) dac_ready = 1;
            step();
            if (m_acc) sample_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
